branch_predictor: RTL and testbench

//   Bimodal branch predictor with direct-mapped tagged target buffer; sits upstream of branch_evaluator.

---
 rtl/branch_predictor_pkg.sv | 32 +++
 rtl/branch_predictor_if.sv | 37 +++
 rtl/branch_predictor_sat_counter2.sv | 22 ++
 rtl/branch_predictor.sv | 78 +++++++
 tb/tb_branch_predictor.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types, widths and PC slicing helpers for the bimodal predictor.
// Counter encoding: MSB set means predict taken.
package branch_predictor_pkg;

    localparam int BP_XLEN       = 32;
    localparam int BP_INDEX_BITS = 6;
    localparam int BP_ENTRIES    = 1 << BP_INDEX_BITS;
    localparam int BP_TAG_W      = BP_XLEN - BP_INDEX_BITS - 2;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_state_t;

    localparam ctr_state_t CTR_RESET = WEAK_NT;
    localparam ctr_state_t CTR_ALLOC = WEAK_T;

    function automatic logic [BP_INDEX_BITS-1:0] index_of(
        input logic [BP_XLEN-1:0] pc
    );
        return pc[BP_INDEX_BITS+1:2];
    endfunction

    function automatic logic [BP_TAG_W-1:0] tag_of(
        input logic [BP_XLEN-1:0] pc
    );
        return pc[BP_XLEN-1:BP_INDEX_BITS+2];
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup and resolved-branch update bundle.
// slave: predictor side; master: fetch/evaluator side.
interface branch_predictor_if;
    import branch_predictor_pkg::*;

    logic [BP_XLEN-1:0] fetch_pc;
    logic               predict_hit;
    logic               predict_taken;
    logic [BP_XLEN-1:0] predict_target;
    logic               update_valid;
    logic [BP_XLEN-1:0] update_pc;
    logic               update_taken;
    logic [BP_XLEN-1:0] update_target;

    modport slave (
        input  fetch_pc,
        output predict_hit,
        output predict_taken,
        output predict_target,
        input  update_valid,
        input  update_pc,
        input  update_taken,
        input  update_target
    );

    modport master (
        output fetch_pc,
        input  predict_hit,
        input  predict_taken,
        input  predict_target,
        output update_valid,
        output update_pc,
        output update_taken,
        output update_target
    );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next state of a 2-bit saturating direction counter.
// Ports: i_ctr current state, i_taken outcome, o_ctr next state.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  ctr_state_t i_ctr,
    input  logic       i_taken,
    output ctr_state_t o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        unique case (i_ctr)
            STRONG_NT: o_ctr = i_taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   o_ctr = i_taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    o_ctr = i_taken ? STRONG_T : WEAK_NT;
            STRONG_T:  o_ctr = i_taken ? STRONG_T : WEAK_T;
            default:   o_ctr = i_ctr;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal predictor with a direct-mapped tagged target buffer.
// Ports: clk, reset (sync, active-high), bp (slave: lookup + update).
module branch_predictor
    import branch_predictor_pkg::*;
(
    input logic               clk,
    input logic               reset,
    branch_predictor_if.slave bp
);

    localparam int XLEN       = BP_XLEN;
    localparam int INDEX_BITS = BP_INDEX_BITS;
    localparam int ENTRIES    = BP_ENTRIES;
    localparam int TAG_W      = BP_TAG_W;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [XLEN-1:0]  r_target [ENTRIES];
    ctr_state_t       r_ctr    [ENTRIES];

    logic [INDEX_BITS-1:0] w_fidx;
    logic [TAG_W-1:0]      w_ftag;
    logic                  w_fhit;
    logic                  w_ftaken;
    logic [XLEN-1:0]       w_seq_pc;

    logic [INDEX_BITS-1:0] w_uidx;
    logic [TAG_W-1:0]      w_utag;
    logic                  w_uhit;
    ctr_state_t            w_ctr_nxt;

    // Lookup reads registered state only, so a same-cycle
    // update is seen by fetch after the edge.
    assign w_fidx   = index_of(bp.fetch_pc);
    assign w_ftag   = tag_of(bp.fetch_pc);
    assign w_fhit   = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);
    assign w_ftaken = w_fhit && r_ctr[w_fidx][1];
    assign w_seq_pc = bp.fetch_pc + XLEN'(4);

    assign bp.predict_hit    = w_fhit;
    assign bp.predict_taken  = w_ftaken;
    assign bp.predict_target = w_ftaken ? r_target[w_fidx]
                                        : w_seq_pc;

    assign w_uidx = index_of(bp.update_pc);
    assign w_utag = tag_of(bp.update_pc);
    assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

    sat_counter2 u_ctr (
        .i_ctr   (r_ctr[w_uidx]),
        .i_taken (bp.update_taken),
        .o_ctr   (w_ctr_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= CTR_RESET;
            end
        end else if (bp.update_valid) begin
            if (w_uhit) begin
                r_ctr[w_uidx] <= w_ctr_nxt;
                if (bp.update_taken)
                    r_target[w_uidx] <= bp.update_target;
            end else if (bp.update_taken) begin
                // Taken miss allocates, evicting any alias.
                r_valid[w_uidx]  <= 1'b1;
                r_tag[w_uidx]    <= w_utag;
                r_target[w_uidx] <= bp.update_target;
                r_ctr[w_uidx]    <= CTR_ALLOC;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
// Expected values are hand-derived from the counter/alias rules.
module tb_branch_predictor;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    branch_predictor_if bp();

    branch_predictor dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h exp=0x%08h",
                     tag, got, exp);
        end
    endtask

    task automatic look(
        input string       tag,
        input logic [31:0] pc,
        input logic        hit,
        input logic        tkn,
        input logic [31:0] tgt
    );
        bp.fetch_pc = pc;
        #1;
        check({tag, ".hit"}, 32'(bp.predict_hit), 32'(hit));
        check({tag, ".tkn"}, 32'(bp.predict_taken), 32'(tkn));
        check({tag, ".tgt"}, bp.predict_target, tgt);
    endtask

    task automatic upd(
        input logic [31:0] pc,
        input logic        tkn,
        input logic [31:0] tgt
    );
        bp.update_valid  = 1'b1;
        bp.update_pc     = pc;
        bp.update_taken  = tkn;
        bp.update_target = tgt;
        @(posedge clk);
        #1;
        bp.update_valid  = 1'b0;
        bp.update_pc     = 32'hxxxx_xxxx;
        bp.update_taken  = 1'bx;
        bp.update_target = 32'hxxxx_xxxx;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bp.fetch_pc      = 32'h0;
        bp.update_valid  = 1'b0;
        bp.update_pc     = 32'h0;
        bp.update_taken  = 1'b0;
        bp.update_target = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        look("rst", 32'h100, 0, 0, 32'h104);

        upd(32'h100, 1, 32'h200);
        look("alloc", 32'h100, 1, 1, 32'h200);

        upd(32'h100, 0, 32'h0);
        look("ctr01", 32'h100, 1, 0, 32'h104);
        upd(32'h100, 0, 32'h0);
        look("ctr00", 32'h100, 1, 0, 32'h104);
        upd(32'h100, 0, 32'h0);
        look("sat00", 32'h100, 1, 0, 32'h104);

        upd(32'h100, 1, 32'h200);
        look("up01", 32'h100, 1, 0, 32'h104);
        upd(32'h100, 1, 32'h200);
        look("up10", 32'h100, 1, 1, 32'h200);
        upd(32'h100, 1, 32'h200);
        look("up11", 32'h100, 1, 1, 32'h200);
        upd(32'h100, 1, 32'h200);
        look("sat11", 32'h100, 1, 1, 32'h200);
        // 11 -> 10 stays taken; NT must not touch target
        upd(32'h100, 0, 32'hdead_beec);
        look("dn10", 32'h100, 1, 1, 32'h200);

        upd(32'h200, 1, 32'h400);
        look("evict", 32'h100, 0, 0, 32'h104);
        look("alias", 32'h200, 1, 1, 32'h400);
        upd(32'h300, 0, 32'h999);
        look("ntmiss", 32'h200, 1, 1, 32'h400);
        look("ntnoal", 32'h300, 0, 0, 32'h304);
        upd(32'h200, 0, 32'h0);
        look("alc10", 32'h200, 1, 0, 32'h204);
        upd(32'h200, 1, 32'h500);
        look("retgt", 32'h200, 1, 1, 32'h500);

        bp.update_valid  = 1'b1;
        bp.update_pc     = 32'h200;
        bp.update_taken  = 1'b0;
        bp.update_target = 32'h0;
        look("same.old", 32'h200, 1, 1, 32'h500);
        @(posedge clk);
        #1;
        bp.update_valid = 1'b0;
        look("same.new", 32'h200, 1, 0, 32'h204);

        look("wrap", 32'hffff_fffc, 0, 0, 32'h0);

        upd(32'h104, 1, 32'h600);
        look("idx1", 32'h104, 1, 1, 32'h600);

        reset            = 1'b1;
        bp.update_valid  = 1'b1;
        bp.update_pc     = 32'h108;
        bp.update_taken  = 1'b1;
        bp.update_target = 32'h700;
        @(posedge clk);
        #1;
        reset           = 1'b0;
        bp.update_valid = 1'b0;
        look("rst.a", 32'h200, 0, 0, 32'h204);
        look("rst.b", 32'h104, 0, 0, 32'h108);
        look("rst.c", 32'h108, 0, 0, 32'h10c);

        $display("Result: errors=%0d of %0d checks",
                 n_errors, n_checks);
        $finish;
    end

endmodule
